// File: rtl/bitwave_fetch_pkg.sv
// bitwave_fetch_pkg: shared constants, FSM state encoding and return-tag
// types for the SRAM tile fetcher and its tag delay line.
package bitwave_fetch_pkg;

  localparam int ADDR_W      = 16;                        // SRAM address width
  localparam int WORD_W      = 32;                        // SRAM data width
  localparam int BUF_AW      = 6;                         // local buffer address width
  localparam int IDX_WORDS   = 7;                         // SRAM words per index vector
  localparam int IDX_FIELDS  = 32;                        // index fields per vector
  localparam int IDX_FIELD_W = 7;                         // bits per index field
  localparam int IDX_VEC_W   = IDX_FIELDS * IDX_FIELD_W;  // 224, equals IDX_WORDS*WORD_W

  // Fetch FSM states; each ISSUE_* state names the kind of read being presented.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE_A   = 3'd1,
    ST_ISSUE_W   = 3'd2,
    ST_ISSUE_IDX = 3'd3,
    ST_WAIT      = 3'd4
  } fetch_state_e;

  // Destination of a returning read word.
  typedef enum logic [1:0] {
    KIND_A   = 2'd0,
    KIND_W   = 2'd1,
    KIND_IDX = 2'd2
  } fetch_kind_e;

  // Tag travelling alongside each read: destination kind and word index.
  typedef struct packed {
    fetch_kind_e       kind;
    logic [BUF_AW-1:0] idx;
  } fetch_tag_t;

endpackage

// File: rtl/sram_tile_fetcher_if.sv
// sram_tile_fetcher_if: global-SRAM read port. The fetcher is the master
// (drives strobe and address), the SRAM is the slave (returns data a fixed
// latency later).
interface sram_tile_fetcher_if;

  logic                                mem_rd_en;
  logic [bitwave_fetch_pkg::ADDR_W-1:0] mem_addr;
  logic [bitwave_fetch_pkg::WORD_W-1:0] mem_rd_data;

  modport master (output mem_rd_en, output mem_addr, input  mem_rd_data);
  modport slave  (input  mem_rd_en, input  mem_addr, output mem_rd_data);

endinterface

// File: rtl/fetch_tag_pipe.sv
// fetch_tag_pipe: MEM_LAT-stage delay line carrying a valid bit and a
// destination tag for every issued SRAM read, so each tag emerges in the
// same cycle as its read data.
module fetch_tag_pipe
  import bitwave_fetch_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  fetch_tag_t in_tag,
  output logic       out_valid,
  output fetch_tag_t out_tag
);

  logic [MEM_LAT-1:0] vld_q;
  fetch_tag_t         tag_q [MEM_LAT];

  // Valid shift register; clearing it on reset drops every in-flight return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Tag payload shift register.
  // NOTE: the payload has no reset; it is only ever consumed when its valid bit is set.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < MEM_LAT; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_valid = vld_q[MEM_LAT-1];
  assign out_tag   = tag_q[MEM_LAT-1];

endmodule

// File: rtl/sram_tile_fetcher.sv
// sram_tile_fetcher: on a Controller request, streams one tile from the global
// SRAM (activations, weights, then 7 index words) into the local buffers,
// assembles the 224-bit sparse index vector and pulses index_en when done.
// Optional feature macro: IDX_CHECK_EN (range-check every index field against
// IDX_LIMIT and raise the sticky idx_err flag).
module sram_tile_fetcher
  import bitwave_fetch_pkg::*;
#(
  parameter int         A_WORDS   = 16,
  parameter int         W_WORDS   = 16,
  parameter int         MEM_LAT   = 2,
  parameter logic [6:0] IDX_LIMIT = 7'd96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sram_en,
  input  logic [ADDR_W-1:0]      sram_a_read_address,
  input  logic [ADDR_W-1:0]      sram_w_read_address,
  input  logic                   tile_done,
  sram_tile_fetcher_if.master    mem,
  output logic                   a_buf_we,
  output logic [BUF_AW-1:0]      a_buf_waddr,
  output logic                   w_buf_we,
  output logic [BUF_AW-1:0]      w_buf_waddr,
  output logic [WORD_W-1:0]      buf_wdata,
  output logic [IDX_VEC_W-1:0]   index_vector_buffer,
  output logic                   index_en,
  output logic                   empty,
  output logic                   busy,
  output logic                   idx_err
);

  fetch_state_e         state_q;
  logic                 rd_en_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    w_base_q;
  fetch_tag_t           tag_q;
  logic                 busy_q;
  logic                 empty_q;
  logic                 index_en_q;
  logic [IDX_VEC_W-1:0] index_vec_q;
  logic [IDX_VEC_W-1:0] asm_q;
  logic [IDX_VEC_W-1:0] asm_d;

  logic       ret_valid;
  fetch_tag_t ret_tag;
  logic       ret_a;
  logic       ret_w;
  logic       ret_idx;
  logic       last_idx;

  // Tags ride alongside the reads so each return knows its destination.
  fetch_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en_q),
    .in_tag    (tag_q),
    .out_valid (ret_valid),
    .out_tag   (ret_tag)
  );

  assign ret_a    = ret_valid && (ret_tag.kind == KIND_A);
  assign ret_w    = ret_valid && (ret_tag.kind == KIND_W);
  assign ret_idx  = ret_valid && (ret_tag.kind == KIND_IDX);
  assign last_idx = ret_idx && (ret_tag.idx == BUF_AW'(IDX_WORDS - 1));

  // Buffer writes happen in the return cycle itself, with no extra register stage.
  assign a_buf_we    = ret_a;
  assign a_buf_waddr = ret_a ? ret_tag.idx : '0;
  assign w_buf_we    = ret_w;
  assign w_buf_waddr = ret_w ? ret_tag.idx : '0;
  assign buf_wdata   = mem.mem_rd_data;

  // Merge a returning index word into its 32-bit slot of the assembly vector.
  always_comb begin
    // NOTE: asm_d takes a full default first so no path leaves it unassigned (no latch).
    asm_d = asm_q;
    for (int k = 0; k < IDX_WORDS; k++) begin
      if (ret_idx && (ret_tag.idx == BUF_AW'(k))) begin
        asm_d[k*WORD_W +: WORD_W] = mem.mem_rd_data;
      end
    end
  end

  // Fetch FSM: issues back-to-back reads, then completes on the last index return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      w_base_q    <= '0;
      tag_q       <= '{kind: KIND_A, idx: '0};
      busy_q      <= 1'b0;
      empty_q     <= 1'b1;
      index_en_q  <= 1'b0;
      index_vec_q <= '0;
      asm_q       <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every branch sees pre-edge values.
      index_en_q <= 1'b0;
      asm_q      <= asm_d;
      unique case (state_q)
        ST_IDLE: begin
          if (empty_q && sram_en) begin
            state_q  <= ST_ISSUE_A;
            rd_en_q  <= 1'b1;
            addr_q   <= sram_a_read_address;
            w_base_q <= sram_w_read_address;
            tag_q    <= '{kind: KIND_A, idx: '0};
            busy_q   <= 1'b1;
          end else if (!empty_q && tile_done) begin
            empty_q <= 1'b1;
          end
        end
        ST_ISSUE_A: begin
          if (tag_q.idx == BUF_AW'(A_WORDS - 1)) begin
            state_q <= ST_ISSUE_W;
            addr_q  <= w_base_q;
            tag_q   <= '{kind: KIND_W, idx: '0};
          end else begin
            addr_q    <= addr_q + 16'd1;
            tag_q.idx <= tag_q.idx + 6'd1;
          end
        end
        ST_ISSUE_W: begin
          // Index words sit directly behind the weights, so the address keeps counting.
          addr_q <= addr_q + 16'd1;
          if (tag_q.idx == BUF_AW'(W_WORDS - 1)) begin
            state_q <= ST_ISSUE_IDX;
            tag_q   <= '{kind: KIND_IDX, idx: '0};
          end else begin
            tag_q.idx <= tag_q.idx + 6'd1;
          end
        end
        ST_ISSUE_IDX: begin
          if (tag_q.idx == BUF_AW'(IDX_WORDS - 1)) begin
            state_q <= ST_WAIT;
            rd_en_q <= 1'b0;
          end else begin
            addr_q    <= addr_q + 16'd1;
            tag_q.idx <= tag_q.idx + 6'd1;
          end
        end
        ST_WAIT: begin
          if (last_idx) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            empty_q     <= 1'b0;
            index_en_q  <= 1'b1;
            index_vec_q <= asm_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_rd_en       = rd_en_q;
  assign mem.mem_addr        = addr_q;
  assign index_vector_buffer = index_vec_q;
  assign index_en            = index_en_q;
  assign empty               = empty_q;
  assign busy                = busy_q;

`ifdef IDX_CHECK_EN
  logic idx_bad;
  logic idx_err_q;

  // Flag any index field of the completed vector that is out of range.
  always_comb begin
    idx_bad = 1'b0;
    for (int f = 0; f < IDX_FIELDS; f++) begin
      if (asm_d[f*IDX_FIELD_W +: IDX_FIELD_W] >= IDX_LIMIT) begin
        idx_bad = 1'b1;
      end
    end
  end

  // Sticky error, set together with index_en and held until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_err_q <= 1'b0;
    end else if (last_idx && idx_bad) begin
      idx_err_q <= 1'b1;
    end
  end

  assign idx_err = idx_err_q;
`else
  assign idx_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_tile_fetcher.sv
// tb_sram_tile_fetcher: randomized self-checking bench for sram_tile_fetcher.
// A behavioural SRAM returns {salt, address}; expected outputs per cycle are
// derived from the tile layout and the fixed burst timeline.
module tb_sram_tile_fetcher;
  import bitwave_fetch_pkg::*;

  localparam int A_WORDS = 16;
  localparam int W_WORDS = 16;
  localparam int MEM_LAT = 2;
  localparam int N       = A_WORDS + W_WORDS + IDX_WORDS;  // reads per tile
  localparam int DONE_C  = N + MEM_LAT + 1;                // index_en cycle after accept

  typedef logic [IDX_VEC_W-1:0] cv_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sram_en;
  logic [15:0]          sram_a_read_address;
  logic [15:0]          sram_w_read_address;
  logic                 tile_done;
  logic                 a_buf_we;
  logic [5:0]           a_buf_waddr;
  logic                 w_buf_we;
  logic [5:0]           w_buf_waddr;
  logic [31:0]          buf_wdata;
  logic [IDX_VEC_W-1:0] index_vector_buffer;
  logic                 index_en;
  logic                 empty;
  logic                 busy;
  logic                 idx_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] salt;
  bit          exp_err;

  sram_tile_fetcher_if bus ();

  sram_tile_fetcher #(
    .A_WORDS   (A_WORDS),
    .W_WORDS   (W_WORDS),
    .MEM_LAT   (MEM_LAT),
    .IDX_LIMIT (7'd96)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sram_en             (sram_en),
    .sram_a_read_address (sram_a_read_address),
    .sram_w_read_address (sram_w_read_address),
    .tile_done           (tile_done),
    .mem                 (bus),
    .a_buf_we            (a_buf_we),
    .a_buf_waddr         (a_buf_waddr),
    .w_buf_we            (w_buf_we),
    .w_buf_waddr         (w_buf_waddr),
    .buf_wdata           (buf_wdata),
    .index_vector_buffer (index_vector_buffer),
    .index_en            (index_en),
    .empty               (empty),
    .busy                (busy),
    .idx_err             (idx_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [15:0] a);
    return {salt, a};
  endfunction

  // Address of the n-th read of a tile (16-bit wrap by truncation).
  function automatic logic [15:0] addr_of(input logic [15:0] ab, input logic [15:0] wb, input int n);
    if (n < A_WORDS) return ab + 16'(n);
    return wb + 16'(n - A_WORDS);
  endfunction

`ifdef IDX_CHECK_EN
  function automatic bit bad(input cv_t v);
    for (int f = 0; f < IDX_FIELDS; f++) begin
      if (v[f*IDX_FIELD_W +: IDX_FIELD_W] >= 7'd96) return 1'b1;
    end
    return 1'b0;
  endfunction
`endif

  // Behavioural SRAM: fixed MEM_LAT read latency.
  logic        sr_vld [MEM_LAT];
  logic [31:0] sr_dat [MEM_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        sr_vld[i] <= 1'b0;
        sr_dat[i] <= '0;
      end
    end else begin
      sr_vld[0] <= bus.mem_rd_en;
      sr_dat[0] <= word(bus.mem_addr);
      for (int i = 1; i < MEM_LAT; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_dat[i] <= sr_dat[i-1];
      end
    end
  end
  assign bus.mem_rd_data = sr_vld[MEM_LAT-1] ? sr_dat[MEM_LAT-1] : 32'h0;

  task automatic check(input string tag, input cv_t got, input cv_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, ".empty"},   cv_t'(empty),               cv_t'(1'b1));
    check({pfx, ".busy"},    cv_t'(busy),                cv_t'(1'b0));
    check({pfx, ".idx_en"},  cv_t'(index_en),            cv_t'(1'b0));
    check({pfx, ".idx_err"}, cv_t'(idx_err),             cv_t'(1'b0));
    check({pfx, ".vec"},     cv_t'(index_vector_buffer), cv_t'(0));
    check({pfx, ".rd_en"},   cv_t'(bus.mem_rd_en),       cv_t'(1'b0));
    check({pfx, ".addr"},    cv_t'(bus.mem_addr),        cv_t'(0));
    check({pfx, ".a_we"},    cv_t'(a_buf_we),            cv_t'(1'b0));
    check({pfx, ".w_we"},    cv_t'(w_buf_we),            cv_t'(1'b0));
    check({pfx, ".a_wa"},    cv_t'(a_buf_waddr),         cv_t'(0));
    check({pfx, ".w_wa"},    cv_t'(w_buf_waddr),         cv_t'(0));
  endtask

  // Request a tile and check every cycle of the burst up to the index_en cycle.
  // Called at a negedge; the following posedge is the accept edge t.
  task automatic run_burst(input logic [15:0] ab, input logic [15:0] wb, input bit hold,
                           input int td_c, input int abort_c);
    cv_t ev;
    int  r;
    bit  exp_rd, exp_a, exp_w;
    for (int k = 0; k < IDX_WORDS; k++) ev[k*32 +: 32] = word(wb + 16'(W_WORDS + k));
    sram_a_read_address = ab;
    sram_w_read_address = wb;
    sram_en             = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= DONE_C; c++) begin
      @(negedge clk);
      if (c == abort_c) break;
      exp_rd = (c <= N);
      r      = c - 1 - MEM_LAT;
      exp_a  = (r >= 0) && (r < A_WORDS);
      exp_w  = (r >= A_WORDS) && (r < A_WORDS + W_WORDS);
      check($sformatf("rd_en c%0d", c), cv_t'(bus.mem_rd_en), cv_t'(exp_rd));
      if (exp_rd) check($sformatf("addr c%0d", c), cv_t'(bus.mem_addr), cv_t'(addr_of(ab, wb, c - 1)));
      check($sformatf("a_we c%0d", c), cv_t'(a_buf_we), cv_t'(exp_a));
      check($sformatf("w_we c%0d", c), cv_t'(w_buf_we), cv_t'(exp_w));
      if (exp_a) begin
        check($sformatf("a_wa c%0d", c), cv_t'(a_buf_waddr), cv_t'(r));
        check($sformatf("a_wd c%0d", c), cv_t'(buf_wdata),   cv_t'(word(ab + 16'(r))));
      end
      if (exp_w) begin
        check($sformatf("w_wa c%0d", c), cv_t'(w_buf_waddr), cv_t'(r - A_WORDS));
        check($sformatf("w_wd c%0d", c), cv_t'(buf_wdata),   cv_t'(word(wb + 16'(r - A_WORDS))));
      end
      check($sformatf("busy c%0d", c),   cv_t'(busy),     cv_t'(c <= N + MEM_LAT));
      check($sformatf("empty c%0d", c),  cv_t'(empty),    cv_t'(c <= N + MEM_LAT));
      check($sformatf("idx_en c%0d", c), cv_t'(index_en), cv_t'(c == DONE_C));
      if (c == DONE_C) begin
        check("vec", index_vector_buffer, ev);
`ifdef IDX_CHECK_EN
        if (bad(ev)) exp_err = 1'b1;
`endif
        check("idx_err", cv_t'(idx_err), cv_t'(exp_err));
      end
      // Drive next-edge inputs: busy-time requests/tile_done must be ignored,
      // and base addresses must already be latched.
      sram_en             = hold ? 1'b1 : 1'($urandom_range(0, 1));
      tile_done           = (c == td_c);
      sram_a_read_address = 16'($urandom);
      sram_w_read_address = 16'($urandom);
    end
  endtask

  // Hold the loaded tile for gap cycles, then release it with tile_done.
  task automatic finish_tile(input int gap, input bit keep_en);
    for (int g = 0; g < gap; g++) begin
      sram_en = keep_en ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold.rd_en",  cv_t'(bus.mem_rd_en), cv_t'(1'b0));
      check("hold.empty",  cv_t'(empty),         cv_t'(1'b0));
      check("hold.busy",   cv_t'(busy),          cv_t'(1'b0));
      check("hold.idx_en", cv_t'(index_en),      cv_t'(1'b0));
      check("hold.err",    cv_t'(idx_err),       cv_t'(exp_err));
    end
    tile_done = 1'b1;
    sram_en   = keep_en ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge clk);
    tile_done = 1'b0;
    sram_en   = keep_en;
    check("done.empty", cv_t'(empty),         cv_t'(1'b1));
    check("done.rd_en", cv_t'(bus.mem_rd_en), cv_t'(1'b0));
    check("done.err",   cv_t'(idx_err),       cv_t'(exp_err));
  endtask

  initial begin
    logic [15:0] ab, wb;
    int          td;
    rst                 = 1'b1;
    sram_en             = 1'b0;
    tile_done           = 1'b0;
    sram_a_read_address = '0;
    sram_w_read_address = '0;
    salt                = '0;
    exp_err             = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.empty", cv_t'(empty), cv_t'(1'b1));

    // Directed: word = address, plain and wrapping weight bases.
    run_burst(16'h0100, 16'h0200, 1'b0, 0, 0);
    finish_tile(4, 1'b0);
    run_burst(16'h0100, 16'hFFF8, 1'b0, 5, 0);
    finish_tile(0, 1'b0);

    // sram_en held high: one burst only, next one right after empty rises.
    run_burst(16'h0300, 16'h0400, 1'b1, 0, 0);
    finish_tile(6, 1'b1);
    run_burst(16'h0500, 16'h0600, 1'b1, 0, 0);
    finish_tile(2, 1'b0);

    // Randomized tiles with random data salt and stray tile_done during the burst.
    for (int it = 0; it < 6; it++) begin
      salt = 16'($urandom);
      ab   = 16'($urandom);
      wb   = 16'($urandom);
      td   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + MEM_LAT)) : 0;
      run_burst(ab, wb, 1'b0, td, 0);
      finish_tile(int'($urandom_range(0, 4)), 1'b0);
    end

    // Reset in the middle of a burst: nothing in flight may land afterwards.
    run_burst(16'h0700, 16'h0800, 1'b0, 0, 20);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    exp_err = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    sram_en   = 1'b0;
    tile_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("quiet.a_we",   cv_t'(a_buf_we),      cv_t'(1'b0));
      check("quiet.w_we",   cv_t'(w_buf_we),      cv_t'(1'b0));
      check("quiet.idx_en", cv_t'(index_en),      cv_t'(1'b0));
      check("quiet.empty",  cv_t'(empty),         cv_t'(1'b1));
      check("quiet.rd_en",  cv_t'(bus.mem_rd_en), cv_t'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
